// File: rtl/guess_judge_if.sv
// Handshake bundle between the number-guessing judge, the random generator and the player.
interface guess_judge_if;
  logic [15:0] rand_in;
  logic        gen_state;
  logic        start;
  logic [15:0] guess;
  logic        guess_valid;
  logic [1:0]  hint;
  logic        hint_valid;
  logic        bad_guess;
  logic [3:0]  tries;
  logic        win;
  logic        lose;
  logic [15:0] secret;

  // Judge side
  modport slave (
    input  rand_in, start, guess, guess_valid,
    output gen_state, hint, hint_valid, bad_guess, tries, win, lose, secret
  );

  // Player / generator side
  modport master (
    output rand_in, start, guess, guess_valid,
    input  gen_state, hint, hint_valid, bad_guess, tries, win, lose, secret
  );
endinterface

// File: rtl/guess_judge.sv
// Game judge: latches a BCD secret from the free-running generator, freezes the generator
// while a round is played, grades guesses with low/high/equal hints and declares win/lose.
module guess_judge #(
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  guess_judge_if.slave  bus
);

  localparam logic [4:0] MaxTries = 5'(MAX_TRIES);

  typedef enum logic [1:0] {StIdle, StPlay, StWin, StLose} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_secret, w_secret_d;
  logic [1:0]  r_hint, w_hint_d;
  logic        r_hint_valid, w_hint_valid_d;
  logic        r_bad_guess, w_bad_guess_d;
  logic [3:0]  r_tries, w_tries_d;
  logic        w_digit_bad;
  logic [4:0]  w_tries_inc;

  // Reject a guess if any nibble is not a decimal digit
  always_comb begin
    w_digit_bad = (bus.guess[15:12] > 4'd9) | (bus.guess[11:8] > 4'd9) |
                  (bus.guess[7:4]   > 4'd9) | (bus.guess[3:0]  > 4'd9);
    // One extra bit so the MAX_TRIES comparison cannot alias on wrap
    w_tries_inc = {1'b0, r_tries} + 5'd1;
  end

  // Next-state and next-output logic for the round FSM
  always_comb begin
    w_state_d      = r_state;
    w_secret_d     = r_secret;
    w_hint_d       = r_hint;
    w_tries_d      = r_tries;
    w_hint_valid_d = 1'b0;
    w_bad_guess_d  = 1'b0;
    unique case (r_state)
      StIdle, StWin, StLose: begin
        // A guess arriving with start is dropped: the round has not begun yet
        if (bus.start) begin
          w_secret_d = bus.rand_in;
          w_tries_d  = 4'd0;
          w_hint_d   = 2'b00;
          w_state_d  = StPlay;
        end
      end
      StPlay: begin
        if (bus.guess_valid) begin
          if (w_digit_bad) begin
            w_bad_guess_d = 1'b1;
          end else begin
            w_hint_valid_d = 1'b1;
            w_tries_d      = w_tries_inc[3:0];
            // BCD digit order matches decimal order, so a binary compare suffices
            if (bus.guess < r_secret) begin
              w_hint_d = 2'b01;
            end else if (bus.guess > r_secret) begin
              w_hint_d = 2'b10;
            end else begin
              w_hint_d = 2'b11;
            end
            if (bus.guess == r_secret) begin
              w_state_d = StWin;
            end else if (w_tries_inc == MaxTries) begin
              w_state_d = StLose;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_secret     <= 16'h0000;
      r_hint       <= 2'b00;
      r_hint_valid <= 1'b0;
      r_bad_guess  <= 1'b0;
      r_tries      <= 4'd0;
    end else begin
      r_state      <= w_state_d;
      r_secret     <= w_secret_d;
      r_hint       <= w_hint_d;
      r_hint_valid <= w_hint_valid_d;
      r_bad_guess  <= w_bad_guess_d;
      r_tries      <= w_tries_d;
    end
  end

  // Generator is frozen only while a round is live; secret stays hidden until it ends
  assign bus.gen_state  = (r_state == StPlay);
  assign bus.win        = (r_state == StWin);
  assign bus.lose       = (r_state == StLose);
  assign bus.secret     = ((r_state == StWin) || (r_state == StLose)) ? r_secret : 16'h0000;
  assign bus.hint       = r_hint;
  assign bus.hint_valid = r_hint_valid;
  assign bus.bad_guess  = r_bad_guess;
  assign bus.tries      = r_tries;

endmodule

// File: tb/tb_guess_judge.sv
// Self-checking bench for guess_judge: directed scenarios plus a randomized run, all graded
// against a decimal-arithmetic model of the game rules.
module tb_guess_judge;

  localparam int unsigned MaxTries = 8;

  logic clk;
  logic rst_n;
  guess_judge_if bus ();

  guess_judge #(.MAX_TRIES(MaxTries)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the game
  bit          m_playing, m_won, m_lost;
  logic [15:0] m_secret;
  int          m_tries;
  logic [1:0]  m_hint;
  bit          m_hv, m_bad;

  function automatic int bcd2int(input logic [15:0] v);
    return 1000 * int'(v[15:12]) + 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic bit has_bad_digit(input logic [15:0] v);
    bit b = 0;
    for (int i = 0; i < 4; i++) begin
      if (((v >> (4 * i)) & 16'hF) > 16'd9) b = 1;
    end
    return b;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v = 16'h0;
    for (int i = 0; i < 4; i++) v = (v << 4) | 16'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [15:0] exp_secret();
    return (m_won || m_lost) ? m_secret : 16'h0000;
  endfunction

  task automatic model_reset();
    m_playing = 0; m_won = 0; m_lost = 0;
    m_secret = 16'h0; m_tries = 0; m_hint = 2'b00; m_hv = 0; m_bad = 0;
  endtask

  // Drive one clock of stimulus, then advance the model to what the DUT should show
  task automatic cycle(input bit st, input logic [15:0] r, input bit gv, input logic [15:0] g);
    int gd, sd;
    bus.start = st; bus.rand_in = r; bus.guess_valid = gv; bus.guess = g;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.guess_valid = 1'b0;
    m_hv = 0; m_bad = 0;
    if (!m_playing) begin
      if (st) begin
        m_secret = r; m_tries = 0; m_hint = 2'b00;
        m_playing = 1; m_won = 0; m_lost = 0;
      end
    end else if (gv) begin
      if (has_bad_digit(g)) begin
        m_bad = 1;
      end else begin
        m_hv = 1;
        m_tries++;
        gd = bcd2int(g);
        sd = bcd2int(m_secret);
        m_hint = (gd < sd) ? 2'b01 : (gd > sd) ? 2'b10 : 2'b11;
        if (gd == sd) begin
          m_won = 1; m_playing = 0;
        end else if (m_tries == int'(MaxTries)) begin
          m_lost = 1; m_playing = 0;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.guess_valid = 1'b0; bus.guess = 16'h0; bus.rand_in = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.gen_state !== 1'b0) begin n_fail++; $display("FAIL reset_gen_state: got %b want 0", bus.gen_state); end
    n_checks++;
    if (bus.hint !== 2'b00) begin n_fail++; $display("FAIL reset_hint: got %b want 00", bus.hint); end
    n_checks++;
    if (bus.hint_valid !== 1'b0 || bus.bad_guess !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got hv=%b bad=%b want 0 0", bus.hint_valid, bus.bad_guess);
    end
    n_checks++;
    if (bus.tries !== 4'd0) begin n_fail++; $display("FAIL reset_tries: got %0d want 0", bus.tries); end
    n_checks++;
    if (bus.win !== 1'b0 || bus.lose !== 1'b0) begin
      n_fail++; $display("FAIL reset_win_lose: got %b %b want 0 0", bus.win, bus.lose);
    end
    n_checks++;
    if (bus.secret !== 16'h0000) begin n_fail++; $display("FAIL reset_secret: got %h want 0000", bus.secret); end
  endtask

  task automatic test_directed_win();
    logic [15:0] gs [3];
    logic [1:0]  hs [3];
    gs[0] = 16'h1000; gs[1] = 16'h9000; gs[2] = 16'h4271;
    hs[0] = 2'b01;    hs[1] = 2'b10;    hs[2] = 2'b11;
    cycle(1'b1, 16'h4271, 1'b0, 16'h0);
    n_checks++;
    if (bus.gen_state !== 1'b1) begin n_fail++; $display("FAIL start_gen_state: got %b want 1", bus.gen_state); end
    n_checks++;
    if (bus.secret !== 16'h0000) begin n_fail++; $display("FAIL start_secret_hidden: got %h want 0000", bus.secret); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1, gs[i]);
      n_checks++;
      if (bus.hint_valid !== 1'b1 || bus.hint !== hs[i]) begin
        n_fail++;
        $display("FAIL directed_hint[%0d]: got hv=%b hint=%b want 1 %b", i, bus.hint_valid, bus.hint, hs[i]);
      end
    end
    n_checks++;
    if (bus.tries !== 4'd3 || bus.win !== 1'b1 || bus.lose !== 1'b0) begin
      n_fail++; $display("FAIL win_state: got tries=%0d win=%b lose=%b want 3 1 0", bus.tries, bus.win, bus.lose);
    end
    n_checks++;
    if (bus.secret !== 16'h4271 || bus.gen_state !== 1'b0) begin
      n_fail++; $display("FAIL win_reveal: got secret=%h gen=%b want 4271 0", bus.secret, bus.gen_state);
    end
    // Guesses in WIN must produce nothing
    cycle(1'b0, 16'h0, 1'b1, 16'h1111);
    n_checks++;
    if (bus.hint_valid !== 1'b0 || bus.tries !== 4'd3 || bus.hint !== 2'b11) begin
      n_fail++; $display("FAIL win_hold: got hv=%b tries=%0d hint=%b want 0 3 11", bus.hint_valid, bus.tries, bus.hint);
    end
  endtask

  task automatic test_bad_guess();
    cycle(1'b1, 16'h3050, 1'b0, 16'h0);
    n_checks++;
    if (bus.tries !== 4'd0 || bus.win !== 1'b0) begin
      n_fail++; $display("FAIL restart_from_win: got tries=%0d win=%b want 0 0", bus.tries, bus.win);
    end
    cycle(1'b0, 16'h0, 1'b1, 16'h12A4);
    n_checks++;
    if (bus.bad_guess !== 1'b1 || bus.hint_valid !== 1'b0) begin
      n_fail++; $display("FAIL bad_guess_pulse: got bad=%b hv=%b want 1 0", bus.bad_guess, bus.hint_valid);
    end
    n_checks++;
    if (bus.tries !== 4'd0 || bus.hint !== 2'b00 || bus.gen_state !== 1'b1) begin
      n_fail++; $display("FAIL bad_guess_hold: got tries=%0d hint=%b gen=%b want 0 00 1", bus.tries, bus.hint, bus.gen_state);
    end
    cycle(1'b0, 16'h0, 1'b0, 16'h0);
    n_checks++;
    if (bus.bad_guess !== 1'b0) begin n_fail++; $display("FAIL bad_guess_one_cycle: got %b want 0", bus.bad_guess); end
  endtask

  task automatic test_lose();
    logic [15:0] g;
    cycle(1'b1, rand_bcd(), 1'b0, 16'h0);
    for (int i = 0; i < int'(MaxTries); i++) begin
      do g = rand_bcd(); while (g == m_secret);
      cycle(1'b0, 16'h0, 1'b1, g);
      n_checks++;
      if (bus.hint_valid !== 1'b1 || bus.hint !== m_hint || bus.tries !== 4'(m_tries)) begin
        n_fail++;
        $display("FAIL lose_guess[%0d]: got hv=%b hint=%b tries=%0d want 1 %b %0d",
                 i, bus.hint_valid, bus.hint, bus.tries, m_hint, m_tries);
      end
      n_checks++;
      if (bus.lose !== m_lost || bus.gen_state !== m_playing) begin
        n_fail++; $display("FAIL lose_flag[%0d]: got lose=%b gen=%b want %b %b", i, bus.lose, bus.gen_state, m_lost, m_playing);
      end
    end
    n_checks++;
    if (bus.lose !== 1'b1 || bus.tries !== 4'd8 || bus.secret !== m_secret) begin
      n_fail++; $display("FAIL lose_final: got lose=%b tries=%0d secret=%h want 1 8 %h", bus.lose, bus.tries, bus.secret, m_secret);
    end
    cycle(1'b0, 16'h0, 1'b1, m_secret);
    n_checks++;
    if (bus.hint_valid !== 1'b0 || bus.bad_guess !== 1'b0 || bus.tries !== 4'd8 || bus.win !== 1'b0) begin
      n_fail++; $display("FAIL ninth_guess: got hv=%b bad=%b tries=%0d win=%b want 0 0 8 0",
                         bus.hint_valid, bus.bad_guess, bus.tries, bus.win);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] gs [3];
    logic [1:0]  hs [3];
    gs[0] = 16'h0000; gs[1] = 16'h9999; gs[2] = 16'h5554;
    hs[0] = 2'b01;    hs[1] = 2'b10;    hs[2] = 2'b01;
    cycle(1'b1, 16'h5555, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1, gs[i]);
      n_checks++;
      if (bus.hint_valid !== 1'b1 || bus.hint !== hs[i] || bus.tries !== 4'(i + 1)) begin
        n_fail++; $display("FAIL b2b[%0d]: got hv=%b hint=%b tries=%0d want 1 %b %0d",
                           i, bus.hint_valid, bus.hint, bus.tries, hs[i], i + 1);
      end
    end
    cycle(1'b0, 16'h0, 1'b0, 16'h0);
    n_checks++;
    if (bus.hint_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got hv=%b want 0", bus.hint_valid); end
  endtask

  task automatic test_start_and_reset();
    // Round in progress with secret 5555 and three tries
    cycle(1'b1, 16'h1234, 1'b0, 16'h0);
    n_checks++;
    if (bus.tries !== 4'd3 || bus.gen_state !== 1'b1) begin
      n_fail++; $display("FAIL start_in_play: got tries=%0d gen=%b want 3 1", bus.tries, bus.gen_state);
    end
    cycle(1'b0, 16'h0, 1'b1, 16'h5555);
    n_checks++;
    if (bus.win !== 1'b1 || bus.secret !== 16'h5555 || bus.hint !== 2'b11) begin
      n_fail++; $display("FAIL start_ignored_secret: got win=%b secret=%h hint=%b want 1 5555 11", bus.win, bus.secret, bus.hint);
    end
    cycle(1'b1, 16'h8765, 1'b0, 16'h0);
    n_checks++;
    if (bus.tries !== 4'd0 || bus.win !== 1'b0 || bus.secret !== 16'h0000 || bus.hint !== 2'b00) begin
      n_fail++; $display("FAIL restart_in_win: got tries=%0d win=%b secret=%h hint=%b want 0 0 0000 00",
                         bus.tries, bus.win, bus.secret, bus.hint);
    end
    cycle(1'b0, 16'h0, 1'b1, 16'h0001);
    // Pull reset between edges and look before any clock can act
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.gen_state !== 1'b0 || bus.tries !== 4'd0 || bus.hint !== 2'b00 || bus.win !== 1'b0 ||
        bus.lose !== 1'b0 || bus.secret !== 16'h0000 || bus.hint_valid !== 1'b0 || bus.bad_guess !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got gen=%b tries=%0d hint=%b hv=%b want all zero",
                         bus.gen_state, bus.tries, bus.hint, bus.hint_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle(1'b0, 16'h0, 1'b1, 16'h0001);
    n_checks++;
    if (bus.hint_valid !== 1'b0 || bus.gen_state !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got hv=%b gen=%b want 0 0", bus.hint_valid, bus.gen_state);
    end
  endtask

  task automatic test_random();
    bit          st, gv;
    logic [15:0] g;
    int          sel;
    for (int c = 0; c < 1500; c++) begin
      st  = ($urandom_range(0, 7) == 0);
      gv  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      g = 16'($urandom);
      else if (sel <= 2) g = m_secret;
      else               g = rand_bcd();
      cycle(st, rand_bcd(), gv, g);
      n_checks++;
      if (bus.hint_valid !== m_hv || bus.bad_guess !== m_bad || bus.hint !== m_hint) begin
        n_fail++; $display("FAIL rand_hint@%0d: got hv=%b bad=%b hint=%b want %b %b %b",
                           c, bus.hint_valid, bus.bad_guess, bus.hint, m_hv, m_bad, m_hint);
      end
      n_checks++;
      if (bus.tries !== 4'(m_tries) || bus.win !== m_won || bus.lose !== m_lost ||
          bus.gen_state !== m_playing || bus.secret !== exp_secret()) begin
        n_fail++; $display("FAIL rand_state@%0d: got tries=%0d win=%b lose=%b gen=%b secret=%h want %0d %b %b %b %h",
                           c, bus.tries, bus.win, bus.lose, bus.gen_state, bus.secret,
                           m_tries, m_won, m_lost, m_playing, exp_secret());
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_win();
    test_bad_guess();
    test_lose();
    test_back_to_back();
    test_start_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
